// File: rtl/hist_pkg.sv
// Shared defaults, derivative type and FSM state encoding for the histogram derivative stream.
package hist_pkg;

    localparam int NUM_BINS_DEFAULT = 256;
    localparam int COUNT_W_DEFAULT  = 16;

    // One extra bit so the difference of two unsigned counts never wraps
    typedef logic signed [COUNT_W_DEFAULT:0] deriv_t;

    typedef enum logic {
        S_FIRST = 1'b0,
        S_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/hist_extrema_tracker.sv
// Running max/min of the per-bin derivative, reported once per frame.
// Only instantiated when HIST_DERIV_EXTREMA_EN is defined.
module hist_extrema_tracker #(
    parameter int DERIV_W = 17,
    parameter int IDX_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      accept,
    input  logic                      in_run,
    input  logic                      first,
    input  logic                      frame_end,
    input  logic signed [DERIV_W-1:0] deriv,
    input  logic [IDX_W-1:0]          idx,
    output logic                      ext_valid,
    output logic signed [DERIV_W-1:0] max_deriv,
    output logic [IDX_W-1:0]          max_idx,
    output logic signed [DERIV_W-1:0] min_deriv,
    output logic [IDX_W-1:0]          min_idx
);

    logic signed [DERIV_W-1:0] run_max, run_min, cand_max, cand_min;
    logic [IDX_W-1:0]          run_max_idx, run_min_idx, cand_max_idx, cand_min_idx;

    // Strict compares keep the earliest index on ties; bin 1 seeds the tracker
    always_comb begin
        cand_max     = run_max;
        cand_max_idx = run_max_idx;
        cand_min     = run_min;
        cand_min_idx = run_min_idx;
        if (first || deriv > run_max) begin
            cand_max     = deriv;
            cand_max_idx = idx;
        end
        if (first || deriv < run_min) begin
            cand_min     = deriv;
            cand_min_idx = idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_max     <= '0;
            run_max_idx <= '0;
            run_min     <= '0;
            run_min_idx <= '0;
            ext_valid   <= 1'b0;
            max_deriv   <= '0;
            max_idx     <= '0;
            min_deriv   <= '0;
            min_idx     <= '0;
        end else begin
            ext_valid <= 1'b0;
            if (accept && in_run) begin
                run_max     <= cand_max;
                run_max_idx <= cand_max_idx;
                run_min     <= cand_min;
                run_min_idx <= cand_min_idx;
            end
            if (accept && frame_end) begin
                ext_valid <= 1'b1;
                if (in_run) begin
                    max_deriv <= cand_max;
                    max_idx   <= cand_max_idx;
                    min_deriv <= cand_min;
                    min_idx   <= cand_min_idx;
                end else begin
                    max_deriv <= '0;
                    max_idx   <= '0;
                    min_deriv <= '0;
                    min_idx   <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/histogram_derivative_stream.sv
// Streaming first difference of histogram bins with a single registered output stage.
// Optional per-frame extrema report enabled by HIST_DERIV_EXTREMA_EN.
//
// state   | meaning
// S_FIRST | next accepted bin is index 0, derivative forced to 0
// S_RUN   | bins 1..end, derivative is bin minus previous bin
module histogram_derivative_stream
    import hist_pkg::*;
#(
    parameter int  NUM_BINS = NUM_BINS_DEFAULT,
    parameter int  COUNT_W  = COUNT_W_DEFAULT,
    localparam int IDX_W    = $clog2(NUM_BINS),
    localparam int DERIV_W  = COUNT_W + 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [COUNT_W-1:0]        i_bin,
    input  logic                      i_last,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic signed [DERIV_W-1:0] o_deriv,
    output logic [IDX_W-1:0]          o_index,
    output logic                      o_last,
`ifdef HIST_DERIV_EXTREMA_EN
    output logic                      o_ext_valid,
    output logic signed [DERIV_W-1:0] o_max_deriv,
    output logic [IDX_W-1:0]          o_max_idx,
    output logic signed [DERIV_W-1:0] o_min_deriv,
    output logic [IDX_W-1:0]          o_min_idx,
`endif
    output logic                      o_frame_err
);

    state_t                    state, state_d;
    logic [COUNT_W-1:0]        prev, prev_d;
    logic [IDX_W-1:0]          idx, idx_d;
    logic signed [DERIV_W-1:0] deriv_d;
    logic                      accept, at_end_idx, frame_end, len_err;

    assign o_ready = !o_valid || i_ready;

    always_comb begin
        accept     = i_valid && o_ready;
        at_end_idx = (idx == IDX_W'(NUM_BINS - 1));
        frame_end  = i_last || at_end_idx;
        // Length is wrong whenever exactly one of the two frame-end causes fires
        len_err    = i_last ^ at_end_idx;
        state_d    = state;
        idx_d      = idx;
        prev_d     = prev;
        deriv_d    = '0;
        if (state == S_RUN)
            deriv_d = $signed({1'b0, i_bin}) - $signed({1'b0, prev});
        if (accept) begin
            prev_d = i_bin;
            if (frame_end) begin
                state_d = S_FIRST;
                idx_d   = '0;
            end else begin
                state_d = S_RUN;
                idx_d   = idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_FIRST;
            idx   <= '0;
            prev  <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            prev  <= prev_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid     <= 1'b0;
            o_deriv     <= '0;
            o_index     <= '0;
            o_last      <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_frame_err <= accept && len_err;
            if (accept) begin
                o_valid <= 1'b1;
                o_deriv <= deriv_d;
                o_index <= idx;
                o_last  <= frame_end;
            end else if (i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

`ifdef HIST_DERIV_EXTREMA_EN
    hist_extrema_tracker #(
        .DERIV_W (DERIV_W),
        .IDX_W   (IDX_W)
    ) u_extrema (
        .clk       (i_clk),
        .rst       (i_rst),
        .accept    (accept),
        .in_run    (state == S_RUN),
        .first     (idx == IDX_W'(1)),
        .frame_end (frame_end),
        .deriv     (deriv_d),
        .idx       (idx),
        .ext_valid (o_ext_valid),
        .max_deriv (o_max_deriv),
        .max_idx   (o_max_idx),
        .min_deriv (o_min_deriv),
        .min_idx   (o_min_idx)
    );
`endif

endmodule

// File: doc/histogram_derivative_stream.md
# histogram_derivative_stream

Streaming, parametrised successor to the combinational histogram derivative. It accepts histogram bins one per handshake in ascending bin order and emits the signed first difference of each bin against its predecessor through a registered ready/valid output. It optionally reports the steepest rising and falling edges per frame for the star-tracker threshold selector. It sits between the histogram RAM readout and the threshold logic.

## Interface
- NUM_BINS, 256, bins per frame (≥2)
- COUNT_W, 16, bin count width (unsigned)
- Derived localparams: IDX_W = $clog2(NUM_BINS); DERIV_W = COUNT_W+1 (signed)
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous, active-high reset
- i_valid  in  1  input bin valid
- o_ready  out  1  block can accept input
- i_bin  in  COUNT_W  bin count
- i_last  in  1  final bin of frame
- o_valid  out  1  derivative valid
- i_ready  in  1  downstream accepts output
- o_deriv  out  DERIV_W  signed bin[k] − bin[k−1]
- o_index  out  IDX_W  bin index k
- o_last  out  1  final derivative of frame
- o_frame_err  out  1  one-cycle pulse: frame length ≠ NUM_BINS
- o_ext_valid, o_max_deriv (DERIV_W), o_max_idx (IDX_W), o_min_deriv (DERIV_W), o_min_idx (IDX_W)  out  extrema report; present only with the extrema macro

## Operation
- One clock domain, one clock. Reset is synchronous and active-high.
- Input transfer occurs when i_valid && o_ready. Output transfer occurs when o_valid && i_ready.
- o_ready = !o_valid || i_ready: a single output register, full throughput, no bubbles.
- FSM S_FIRST / S_RUN:
  - S_FIRST: the accepted bin is index 0. Emit o_deriv = 0, store bin in prev, and move to S_RUN unless the frame ends.
  - S_RUN: emit sign-extended i_bin − prev (COUNT_W+1 bits, never wraps), update prev, and increment the index.
- Frame end is the earlier of i_last or index == NUM_BINS−1. On the frame-end transfer:
  - o_last = 1; the FSM returns to S_FIRST and the index clears to 0.
  - o_frame_err pulses when i_last arrives with index ≠ NUM_BINS−1, or when index == NUM_BINS−1 without i_last.
- i_last on bin 0 gives a one-bin frame: deriv 0, o_last = 1, o_frame_err = 1.
- Input is ignored while o_ready = 0. i_bin, i_last and i_valid must stay stable until accepted; the block does not check this.

## Timing
- Latency is 1 cycle from input transfer to o_valid. Under stall, outputs hold stable until accepted.
- o_frame_err and o_ext_valid assert in the same cycle that o_last first becomes valid. Each is high for exactly one cycle regardless of stall.
- Reset values: o_valid = 0; o_deriv, o_index, o_last = 0; o_frame_err = 0; o_ext_valid = 0; all extrema outputs = 0; FSM = S_FIRST; prev = 0; index = 0; o_ready = 1 from the first cycle after reset.
- Reset mid-frame drops the partial frame and any pending output. No o_last or error is issued for the dropped frame.

## Configuration
- HIST_DERIV_EXTREMA_EN defined:
  - Track running max/min of o_deriv over bins 1..end, using strict compare so the lowest index wins ties.
  - The tracker initialises from bin 1.
  - At frame end, present results with an o_ext_valid pulse.
  - A one-bin frame reports all zeros.
- Undefined: the extrema ports and logic are absent. All other behaviour is identical.

## Structure
- Package hist_pkg: NUM_BINS_DEFAULT, COUNT_W_DEFAULT, the deriv_t signed typedef helper, and the FSM state enum.
- Extrema tracking goes in a sub-module, hist_extrema_tracker, instantiated under the macro.
- The datapath stays in the top module.

## Test plan
- NUM_BINS=256, bins k*3 for k=0..255, i_last on 255, i_ready=1 → deriv 0 then 3×255, o_last on index 255, no err, 1 output/cycle.
- Bins 100, 40, 65535, 0 with NUM_BINS=4 → deriv 0, −60, +65495, −65535 (17-bit signed), no wrap.
- i_ready toggling 1010… and random i_valid gaps over a 256-bin frame → outputs identical to the unstalled case; o_ready low only when o_valid && !i_ready.
- i_last at index 9 → o_last at index 9, one o_frame_err pulse; the next frame restarts at index 0 with deriv 0.
- Extrema on, bins 0, 10, 50, 50, 5, 45, 0 → max +40 at idx 2, min −45 at idx 4 (tie at idx 6 not taken), o_ext_valid with o_last.
- i_rst asserted at index 100 → all outputs 0 next cycle; a following full frame is correct with no error.
